// File: rtl/se_instr_mem_if.sv
// Fetch/load bus for the instruction memory: PC in/out, sequential next address,
// fetched word and the program-load write port.
interface se_instr_mem_if;
  logic [63:0] pci_i;
  logic [63:0] pco_o;
  logic [31:0] loadData_i;
  logic [63:0] loadAddr_i;
  logic        wrEn_i;
  logic [63:0] nextAddr_o;
  logic [31:0] instr_o;

  modport master (
    output pci_i, loadData_i, loadAddr_i, wrEn_i,
    input  pco_o, nextAddr_o, instr_o
  );

  modport slave (
    input  pci_i, loadData_i, loadAddr_i, wrEn_i,
    output pco_o, nextAddr_o, instr_o
  );
endinterface

// File: rtl/se_instr_mem_top.sv
// 1024 x 32 instruction memory with registered PC and zero-latency fetch.
// IMEM_RANGE_CHECK_EN: drop loads at or above 4 KB and fetch NOPs there instead of aliasing.
module se_instr_mem_top (
  input  logic           clk_i,
  input  logic           rst_i,
  se_instr_mem_if.slave  bus
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic [31:0] mem [1024];
  logic [63:0] pc_q, pc_d;
  logic [9:0]  wr_idx, rd_idx;
  logic        wr_en;
  logic        wr_in_range, rd_in_range;
  logic        unused_addr_bits;

  assign wr_idx = bus.loadAddr_i[11:2];
  assign rd_idx = pc_q[11:2];

`ifdef IMEM_RANGE_CHECK_EN
  assign wr_in_range = (bus.loadAddr_i[63:12] == '0);
  assign rd_in_range = (pc_q[63:12] == '0);
`else
  assign wr_in_range = 1'b1;
  assign rd_in_range = 1'b1;
`endif

  // Byte-offset bits never select anything; upper bits only matter with range checking.
  assign unused_addr_bits = ^{bus.loadAddr_i[63:12], bus.loadAddr_i[1:0], pc_q[1:0]};

  // A program load freezes the PC so fetch resumes where it left off.
  always_comb begin
    pc_d  = bus.wrEn_i ? pc_q : bus.pci_i;
    wr_en = bus.wrEn_i & ~rst_i & wr_in_range;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Contents survive reset; only the PC is cleared.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_idx] <= bus.loadData_i;
    end
  end

  always_comb begin
    bus.pco_o      = pc_q;
    bus.nextAddr_o = pc_q + 64'd4;
    bus.instr_o    = rd_in_range ? mem[rd_idx] : Nop;
  end

endmodule

// File: tb/tb_se_instr_mem_top.sv
// Randomized self-checking bench for se_instr_mem_top against an array-based memory model.
module tb_se_instr_mem_top;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] model_mem [1024];
  logic [63:0] exp_pc;

  se_instr_mem_if bus ();

  se_instr_mem_top dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_instr(input logic [63:0] pc);
`ifdef IMEM_RANGE_CHECK_EN
    if (pc >= 64'h1000) return 32'h0000_0013;
`endif
    return model_mem[(pc / 4) % 1024];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fetch(input string tag);
    check({tag, "_pc"}, bus.pco_o, exp_pc);
    check({tag, "_next"}, bus.nextAddr_o, exp_pc + 64'd4);
    check({tag, "_instr"}, {32'h0, bus.instr_o}, {32'h0, exp_instr(exp_pc)});
  endtask

  initial begin
    logic [31:0] d;
    logic [63:0] a;

    bus.pci_i      = 64'h0;
    bus.loadData_i = 32'h0;
    bus.loadAddr_i = 64'h0;
    bus.wrEn_i     = 1'b0;
    exp_pc         = 64'h0;

    repeat (3) tick();
    check("rst_pc", bus.pco_o, 64'h0);
    check("rst_next", bus.nextAddr_o, 64'h4);
    rst = 1'b0;

    // Load the whole program with random words; PC must stay frozen at 0.
    for (int i = 0; i < 1024; i++) begin
      d = $urandom();
      bus.wrEn_i     = 1'b1;
      bus.loadAddr_i = 64'(i) * 4;
      bus.loadData_i = d;
      bus.pci_i      = {$urandom(), $urandom()};
      model_mem[i]   = d;
      tick();
      check("load_pc_frozen", bus.pco_o, 64'h0);
    end
    bus.wrEn_i = 1'b0;

    // Sequential fetch walk 0 .. 0xFFC, feeding nextAddr back as the next PC.
    bus.pci_i = 64'h0;
    tick();
    exp_pc = 64'h0;
    for (int k = 0; k < 1024; k++) begin
      check_fetch("seq");
      bus.pci_i = bus.nextAddr_o;
      if (k != 1023) begin
        tick();
        exp_pc = exp_pc + 64'd4;
      end
    end
    check("last_next", bus.nextAddr_o, 64'h1000);

    for (int t = 0; t < 5; t++) begin
      a = 64'($urandom_range(0, 1023)) * 4;
      bus.pci_i = a;
      tick();
      exp_pc = a;
      check_fetch("branch");
    end

    bus.pci_i = 64'h6;
    tick();
    exp_pc = 64'h6;
    check("misalign_instr", {32'h0, bus.instr_o}, {32'h0, model_mem[1]});
    check("misalign_next", bus.nextAddr_o, 64'hA);

    bus.pci_i = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    check_fetch("wrap");
    check("wrap_next_zero", bus.nextAddr_o, 64'h0);

    // Overwrite the word under the PC; new value must show right after the edge.
    bus.pci_i = 64'h100;
    tick();
    exp_pc = 64'h100;
    d = $urandom();
    bus.wrEn_i     = 1'b1;
    bus.loadAddr_i = 64'h100;
    bus.loadData_i = d;
    bus.pci_i      = 64'h300;
    model_mem[64]  = d;
    tick();
    bus.wrEn_i = 1'b0;
    check_fetch("wr_through");

    // Asynchronous reset mid-cycle from PC 0x200, with a write attempted under reset.
    bus.pci_i = 64'h200;
    tick();
    exp_pc = 64'h200;
    check_fetch("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    exp_pc = 64'h0;
    check_fetch("async_rst");
    bus.wrEn_i     = 1'b1;
    bus.loadAddr_i = 64'h0;
    bus.loadData_i = ~model_mem[0];
    tick();
    tick();
    bus.wrEn_i = 1'b0;
    check_fetch("rst_no_write");
    bus.pci_i = 64'h40;
    rst = 1'b0;
    tick();
    exp_pc = 64'h40;
    check_fetch("post_rst_first");
    bus.pci_i = 64'h0;
    tick();
    exp_pc = 64'h0;
    check_fetch("mem_kept");

    // Out-of-range load and fetch.
    bus.wrEn_i     = 1'b1;
    bus.loadAddr_i = 64'h1000;
    bus.loadData_i = 32'hDEAD_BEEF;
`ifndef IMEM_RANGE_CHECK_EN
    model_mem[0] = 32'hDEAD_BEEF;
`endif
    tick();
    bus.wrEn_i = 1'b0;
    bus.pci_i  = 64'h1000;
    tick();
    exp_pc = 64'h1000;
    check_fetch("oor_fetch");
    bus.pci_i = 64'h0;
    tick();
    exp_pc = 64'h0;
    check_fetch("oor_mem0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
